// File: rtl/gf_div_sequencer.sv
// GF(2^M_C) divider q = a / b that time-shares one external multiplier (b^-1 = b^(2^M_C-2), then a*b^-1).
// Optional macro GF_DIV_SEQ_ZERO_SHORTCUT_EN: a==0 with b!=0 finishes on accept without any multiplies.
module gf_div_sequencer #(
  parameter int M_C = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [M_C-1:0] in_a,
  input  logic [M_C-1:0] in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [M_C-1:0] out_q,
  output logic           out_div_zero,
  output logic           mul_req_valid,
  input  logic           mul_req_ready,
  output logic [M_C-1:0] mul_x,
  output logic [M_C-1:0] mul_y,
  input  logic           mul_res_valid,
  input  logic [M_C-1:0] mul_res
);

  localparam int KW = $clog2(M_C);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SQ_REQ,
    S_SQ_WAIT,
    S_ACC_REQ,
    S_ACC_WAIT,
    S_FIN_REQ,
    S_FIN_WAIT,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_in_ready;
  logic [M_C-1:0]  r_a;
  logic [M_C-1:0]  r_sq;
  logic [M_C-1:0]  r_acc;
  logic [M_C-1:0]  r_q;
  logic            r_div_zero;
  logic [KW-1:0]   r_k;

  logic            w_accept;
  logic            w_zero_div;
  logic            w_skip;
  logic            w_last_k;

  assign w_accept   = in_valid && r_in_ready;
  assign w_zero_div = (in_b == '0);
  assign w_last_k   = (r_k == KW'(M_C - 1));

`ifdef GF_DIV_SEQ_ZERO_SHORTCUT_EN
  assign w_skip = w_zero_div || (in_a == '0);
`else
  assign w_skip = w_zero_div;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_accept)      w_next = w_skip ? S_DONE : S_SQ_REQ;
      S_SQ_REQ:   if (mul_req_ready) w_next = S_SQ_WAIT;
      S_SQ_WAIT:  if (mul_res_valid) w_next = S_ACC_REQ;
      S_ACC_REQ:  if (mul_req_ready) w_next = S_ACC_WAIT;
      S_ACC_WAIT: if (mul_res_valid) w_next = w_last_k ? S_FIN_REQ : S_SQ_REQ;
      S_FIN_REQ:  if (mul_req_ready) w_next = S_FIN_WAIT;
      S_FIN_WAIT: if (mul_res_valid) w_next = S_DONE;
      S_DONE:     if (out_ready)     w_next = S_IDLE;
      default:                       w_next = S_IDLE;
    endcase
  end

  // Operands come straight from registers that only change in WAIT states, so they hold while stalled.
  always_comb begin
    mul_x = r_sq;
    mul_y = r_sq;
    case (r_state)
      S_ACC_REQ: mul_x = r_acc;
      S_FIN_REQ: begin
        mul_x = r_a;
        mul_y = r_acc;
      end
      default: ;
    endcase
  end

  assign mul_req_valid = (r_state == S_SQ_REQ) || (r_state == S_ACC_REQ) || (r_state == S_FIN_REQ);
  assign out_valid     = (r_state == S_DONE);
  assign in_ready      = r_in_ready;
  assign out_q         = r_q;
  assign out_div_zero  = r_div_zero;

  // in_ready is registered so it stays low for the first cycle after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next == S_IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a        <= '0;
      r_sq       <= '0;
      r_acc      <= '0;
      r_q        <= '0;
      r_div_zero <= 1'b0;
      r_k        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a        <= in_a;
            r_sq       <= in_b;
            r_acc      <= M_C'(1);
            r_k        <= KW'(1);
            r_q        <= '0;
            r_div_zero <= w_zero_div;
          end
        end
        S_SQ_WAIT: begin
          if (mul_res_valid) r_sq <= mul_res;
        end
        S_ACC_WAIT: begin
          if (mul_res_valid) begin
            r_acc <= mul_res;
            if (!w_last_k) r_k <= r_k + KW'(1);
          end
        end
        S_FIN_WAIT: begin
          if (mul_res_valid) begin
            r_q        <= mul_res;
            r_div_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
